draw_fsm_line: RTL

- Runtime-programmable line rasteriser for the 640x480 VGA frame buffer path. It replaces the fixed-endpoint, fixed-orientation diagonal draw blocks.
- Accepts two endpoints and a colour code per command. Walks the line with integer Bresenham, one pixel per accepted write.
- Emits frame-buffer address, pixel data and a write strobe, with ready backpressure from the frame-buffer arbiter.

---
 rtl/draw_fsm_line.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/draw_fsm_line.sv
// draw_fsm_line: Bresenham line rasteriser driving frame-buffer writes with ready backpressure.
// Define DRAW_CLIP_EN to skip pixels outside the visible window instead of writing them.
module draw_fsm_line #(
  parameter int H_TOTAL   = 800,
  parameter int COORD_W   = 16,
  parameter int ADDR_W    = 19,
  parameter int PIX_W     = 12,
  parameter int H_VIS_MIN = 144,
  parameter int H_VIS_MAX = 783,
  parameter int V_VIS_MIN = 35,
  parameter int V_VIS_MAX = 514
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [2:0]         color,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  addr,
  output logic [PIX_W-1:0]   data_out
);
  localparam int DW = COORD_W + 2;
  localparam int PW = COORD_W + 32;
  localparam int CW = PIX_W / 3;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PLOT, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [COORD_W-1:0]  xdiff, ydiff;
  logic signed [DW:0]  e2, dx_ext, dy_ext;
  logic                x_step, y_step, plot_vis, advance, at_end;
  logic [PW-1:0]       addr_full;

  function automatic logic [PIX_W-1:0] decode_color(input logic [2:0] code);
    logic [PIX_W-1:0] pix;
    pix = '0;
    case (code)
      3'd1:    pix = {{CW{1'b1}}, {(PIX_W-CW){1'b0}}};
      3'd2:    pix = {{CW{1'b0}}, {CW{1'b1}}, {(PIX_W-2*CW){1'b0}}};
      3'd3:    pix = {{(PIX_W-CW){1'b0}}, {CW{1'b1}}};
      3'd4:    pix = '1;
      default: pix = '0;
    endcase
    return pix;
  endfunction

`ifdef DRAW_CLIP_EN
  assign plot_vis = (x_q >= COORD_W'(H_VIS_MIN)) && (x_q <= COORD_W'(H_VIS_MAX)) &&
                    (y_q >= COORD_W'(V_VIS_MIN)) && (y_q <= COORD_W'(V_VIS_MAX));
`else
  logic unused_clip_cfg;
  assign unused_clip_cfg = ^{32'(H_VIS_MIN), 32'(H_VIS_MAX), 32'(V_VIS_MIN), 32'(V_VIS_MAX)};
  assign plot_vis = 1'b1;
`endif

  assign addr_full = PW'(y_q) * PW'(H_TOTAL) + PW'(x_q);
  assign addr      = addr_full[ADDR_W-1:0];
  assign data_out  = pix_q;
  assign busy      = (state_q == S_SETUP) || (state_q == S_PLOT);
  assign done      = (state_q == S_FINISH);
  assign wr_en     = (state_q == S_PLOT) && plot_vis;
  // A clipped pixel consumes its cycle without waiting for the arbiter.
  assign advance   = (state_q == S_PLOT) && (wr_ready || !plot_vis);
  assign at_end    = (x_q == x1_q) && (y_q == y1_q);

  assign dx_ext = {dx_q[DW-1], dx_q};
  assign dy_ext = {dy_q[DW-1], dy_q};
  assign e2     = {err_q, 1'b0};
  assign x_step = (e2 >= dy_ext);
  assign y_step = (e2 <= dx_ext);
  assign xdiff  = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
  assign ydiff  = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x_d      = x_q;
    y_d      = y_q;
    pix_d    = pix_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          pix_d   = decode_color(color);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = DW'(xdiff);
        dy_d     = -DW'(ydiff);
        err_d    = DW'(xdiff) - DW'(ydiff);
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        x_d      = x0_q;
        y_d      = y0_q;
        state_d  = S_PLOT;
      end
      S_PLOT: begin
        if (advance) begin
          if (at_end) begin
            state_d = S_FINISH;
          end else begin
            // Both axis steps may fire together; err accumulates both deltas.
            err_d = err_q + (x_step ? dy_q : {DW{1'b0}}) + (y_step ? dx_q : {DW{1'b0}});
            if (x_step) x_d = sx_neg_q ? x_q - ONE : x_q + ONE;
            if (y_step) y_d = sy_neg_q ? y_q - ONE : y_q + ONE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule
